sha256_msg_schedule: RTL and testbench
======================================

# sha256_msg_schedule

Message-schedule stage of the SHA-256 core. Accepts one 512-bit message block as 16 big-endian 32-bit words over a valid/ready stream, then emits the 64 schedule words W[0..63] one per handshake to the compression round stage. Expansion uses the core's existing sigma0/sigma1 function block over a 16-word sliding window, so each W[t] costs one cycle and no multi-cycle arithmetic.

## Interface
Parameters: none (widths fixed by SHA-256).
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- clear  in  1  synchronous abort; returns to LOAD, discards window contents
- in_valid  in  1  input word valid
- in_ready  out  1  block accepts an input word (LOAD state only)
- in_word  in  32  message word, M[0] first
- out_valid  out  1  schedule word valid (STREAM state only)
- out_ready  in  1  downstream accepts the schedule word
- out_word  out  32  W[t], or W[t]+K[t] (see Configuration)
- out_idx  out  6  round index t of out_word
- out_last  out  1  high with out_valid when out_idx == 63

## Operation
- Storage: window w[0..15] of 32-bit registers, 6-bit counter cnt, state ∈ {LOAD, STREAM}.
- Shift operation (common to both states): w[i] ← w[i+1] for i = 0..14; w[15] ← new entry.
- LOAD: in_ready = 1. On in_valid & in_ready: shift with new entry = in_word; cnt += 1. The 16th accepted word (cnt == 15) sets cnt ← 0 and moves to STREAM. After LOAD, w[0] = M[0].
- STREAM: out_valid = 1, out_idx = cnt, W[t] = w[0]. On out_valid & out_ready: shift with new entry = sigma1(w[14]) + w[9] + sigma0(w[1]) + w[0], mod 2^32; cnt += 1. Handshake at cnt == 63 sets cnt ← 0 and moves to LOAD. The formula applies uniformly for every t, and words beyond W[63] are computed but discarded.
- sigma0/sigma1 come from one sha256_funcs instance: x = w[1], y = w[14]. Its other outputs are unused.
- clear, sampled at a rising edge, sets state ← LOAD and cnt ← 0. It takes priority over any same-cycle handshake; that handshake is dropped and counted nowhere. Window contents are not cleared and are overwritten by the next load.
- Inputs offered outside LOAD are ignored because in_ready = 0.

## Timing
- Reset (rst_n low, asynchronous): state = LOAD, cnt = 0, w = 0.
- Reset values: in_ready = 1, out_valid = 0, out_idx = 0, out_last = 0, out_word = 0 (or K[0] with the Configuration macro enabled).
- in_ready, out_valid, out_idx and out_last decode directly from registered state and cnt; there is no combinational path from in_valid or out_ready to any output.
- out_word depends only on the registered w[0] (and cnt, with the Configuration macro enabled).
- Latency: out_valid rises the cycle after the 16th input handshake. in_ready rises the cycle after the W[63] handshake.
- Best-case throughput: 80 cycles per block (16 load + 64 stream).
- Backpressure: while out_valid & !out_ready, out_word, out_idx and out_last hold stable. Input bubbles stall LOAD without losing words.
- An asynchronous reset mid-LOAD or mid-STREAM returns immediately to the reset values. No partial block survives.

## Configuration
- SHA256_SCHED_KADD_EN defined: out_word = w[0] + K[out_idx] mod 2^32, with the round-constant add folded into this stage. The adder is combinational after w[0] and the K ROM.
- SHA256_SCHED_KADD_EN undefined: out_word = w[0], with no K ROM and no adder. Handshake timing is identical in both builds.

## Structure
- Shared package sha256_pkg holds:
  - the word width constant (32), the block word count (16) and the round count (64);
  - the K[0..63] round-constant array;
  - the state enum {LOAD, STREAM}.
- Sub-module: one instance of the existing sha256_funcs for sigma0/sigma1. No other hierarchy.

## Test plan
- Reset: hold rst_n low, then release. Required: in_ready = 1, out_valid = 0, out_idx = 0, out_last = 0.
- "abc" padded block, out_ready tied high. Input: 0x61626380, fourteen zeros, 0x00000018. Required:
  - out_valid rises 1 cycle after the last input;
  - W0 = 0x61626380, W15 = 0x00000018, W16 = 0x61626380, W17 = 0x000F0000;
  - out_last only at idx 63;
  - in_ready = 1 the next cycle.
- Backpressure: same block, out_ready toggling 1/0 every cycle. Required: out_word and out_idx stable whenever valid & !ready; all 64 words match the previous run.
- Input bubbles: in_valid low on every third cycle during LOAD. Required: exactly 16 words accepted and identical W sequence.
- Abort: clear asserted during the idx = 30 handshake cycle. Required: next cycle out_valid = 0 and in_ready = 1. Reloading "abc" restarts with W0 = 0x61626380, idx = 0.
- KADD build: "abc" block. Required: first out_word = 0xA3EC9318 (0x61626380 + 0x428A2F98). Async reset asserted mid-STREAM returns all outputs to reset values in the same cycle.

Source files
------------

// File: rtl/sha256_pkg.sv
// sha256_pkg
// Definitions shared by the SHA-256 core: the word width, the block and round
// sizes, the K[0..63] round constants and the message-schedule state encoding.
package sha256_pkg;

   localparam int WORD_W      = 32;
   localparam int BLOCK_WORDS = 16;
   localparam int ROUNDS      = 64;

   localparam logic [31:0] K [0:63] = '{
      32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
      32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
      32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
      32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
      32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
      32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
      32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
      32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
      32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
      32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
      32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
      32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
      32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
      32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
      32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
      32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
   };

   typedef enum logic {
      LOAD,
      STREAM
   } sched_state_t;

endpackage

// File: rtl/sha256_funcs.sv
// sha256_funcs
// Purely combinational SHA-256 rotate/shift functions.
// Ports:
//   x      in  32  operand for the "0" functions
//   y      in  32  operand for the "1" functions
//   sig0   out 32  small sigma0(x) = ROTR7 ^ ROTR18 ^ SHR3
//   sig1   out 32  small sigma1(y) = ROTR17 ^ ROTR19 ^ SHR10
//   bsig0  out 32  big Sigma0(x)   = ROTR2 ^ ROTR13 ^ ROTR22
//   bsig1  out 32  big Sigma1(y)   = ROTR6 ^ ROTR11 ^ ROTR25
module sha256_funcs
   import sha256_pkg::*;
(
   input  logic [WORD_W-1:0] x,
   input  logic [WORD_W-1:0] y,
   output logic [WORD_W-1:0] sig0,
   output logic [WORD_W-1:0] sig1,
   output logic [WORD_W-1:0] bsig0,
   output logic [WORD_W-1:0] bsig1
);

   // Rotations are written as bit-field concatenations so they cost only wiring.
   assign sig0  = {x[6:0],  x[31:7]}  ^ {x[17:0], x[31:18]} ^ {3'b000, x[31:3]};
   assign sig1  = {y[16:0], y[31:17]} ^ {y[18:0], y[31:19]} ^ {10'd0, y[31:10]};
   assign bsig0 = {x[1:0],  x[31:2]}  ^ {x[12:0], x[31:13]} ^ {x[21:0], x[31:22]};
   assign bsig1 = {y[5:0],  y[31:6]}  ^ {y[10:0], y[31:11]} ^ {y[24:0], y[31:25]};

endmodule

// File: rtl/sha256_msg_schedule.sv
// sha256_msg_schedule
// Message-schedule stage of the SHA-256 core. Loads one 512-bit block as 16
// big-endian 32-bit words, then streams W[0..63] one per output handshake.
// A 16-word sliding window expands one new word per handshake.
// Ports:
//   clk       in   1   clock, rising edge
//   rst_n     in   1   asynchronous active-low reset
//   clear     in   1   synchronous abort back to LOAD
//   in_valid  in   1   input word valid
//   in_ready  out  1   high in LOAD
//   in_word   in  32   message word, M[0] first
//   out_valid out  1   high in STREAM
//   out_ready in   1   downstream accepts out_word
//   out_word  out 32   W[t] (W[t]+K[t] when SHA256_SCHED_KADD_EN is defined)
//   out_idx   out  6   round index t
//   out_last  out  1   high with out_valid at t == 63
// Build option: define SHA256_SCHED_KADD_EN to fold the K[t] add into out_word.
module sha256_msg_schedule
   import sha256_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              clear,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [WORD_W-1:0] in_word,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [WORD_W-1:0] out_word,
   output logic [5:0]        out_idx,
   output logic              out_last
);

   sched_state_t      state, state_nxt;
   logic [5:0]        cnt, cnt_nxt;
   logic [WORD_W-1:0] w [0:BLOCK_WORDS-1];
   logic              shift_en;
   logic [WORD_W-1:0] new_entry;
   logic [WORD_W-1:0] s0, s1, expand;
   logic [WORD_W-1:0] unused_bsig0, unused_bsig1;

   sha256_funcs u_funcs (
      .x     (w[1]),
      .y     (w[14]),
      .sig0  (s0),
      .sig1  (s1),
      .bsig0 (unused_bsig0),
      .bsig1 (unused_bsig1)
   );

   // With w[0] = W[t], the window holds W[t..t+15], so W[t+16] needs
   // W[t+14], W[t+9], W[t+1] and W[t]. It is also computed past t = 48 and
   // simply never emitted.
   assign expand = s1 + w[9] + s0 + w[0];

   // Output handshake decode uses registered state only, so ready/valid
   // inputs never reach an output combinationally.
   assign in_ready  = (state == LOAD);
   assign out_valid = (state == STREAM);
   assign out_idx   = out_valid ? cnt : 6'd0;
   assign out_last  = out_valid && (cnt == 6'(ROUNDS - 1));

`ifdef SHA256_SCHED_KADD_EN
   assign out_word = w[0] + K[out_idx];
`else
   assign out_word = w[0];
`endif

   // Next-state logic: clear overrides and drops any same-cycle handshake.
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      shift_en  = 1'b0;
      new_entry = in_word;
      if (clear) begin
         state_nxt = LOAD;
         cnt_nxt   = 6'd0;
      end else begin
         case (state)
            LOAD: begin
               if (in_valid) begin
                  shift_en  = 1'b1;
                  new_entry = in_word;
                  if (cnt == 6'(BLOCK_WORDS - 1)) begin
                     cnt_nxt   = 6'd0;
                     state_nxt = STREAM;
                  end else begin
                     cnt_nxt = cnt + 6'd1;
                  end
               end
            end
            STREAM: begin
               if (out_ready) begin
                  shift_en  = 1'b1;
                  new_entry = expand;
                  if (cnt == 6'(ROUNDS - 1)) begin
                     cnt_nxt   = 6'd0;
                     state_nxt = LOAD;
                  end else begin
                     cnt_nxt = cnt + 6'd1;
                  end
               end
            end
            default: begin
               state_nxt = LOAD;
               cnt_nxt   = 6'd0;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= LOAD;
         cnt   <= 6'd0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
      end
   end

   // Window shifts toward w[0]. A clear leaves it alone; the next load
   // overwrites it completely.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < BLOCK_WORDS; i++) begin
            w[i] <= '0;
         end
      end else if (shift_en) begin
         for (int i = 0; i < BLOCK_WORDS - 1; i++) begin
            w[i] <= w[i+1];
         end
         w[BLOCK_WORDS-1] <= new_entry;
      end
   end

endmodule

// File: tb/tb_sha256_msg_schedule.sv
// tb_sha256_msg_schedule
// Randomised and directed bench for sha256_msg_schedule. The reference model
// computes the textbook SHA-256 schedule
// W[t] = s1(W[t-2]) + W[t-7] + s0(W[t-15]) + W[t-16] over a 64-entry array.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_sha256_msg_schedule;

   logic        clk;
   logic        rst_n;
   logic        clear;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_word;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_word;
   logic [5:0]  out_idx;
   logic        out_last;

   int total = 0;
   int bad   = 0;

   logic [31:0] msg   [16];
   logic [31:0] exp_w [64];
   logic [31:0] cap   [64];

`ifdef SHA256_SCHED_KADD_EN
   localparam bit KADD = 1'b1;
`else
   localparam bit KADD = 1'b0;
`endif

   localparam logic [31:0] KREF [64] = '{
      32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
      32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
      32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
      32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
      32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
      32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
      32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
      32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
   };

   sha256_msg_schedule dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .clear     (clear),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_word   (in_word),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_word  (out_word),
      .out_idx   (out_idx),
      .out_last  (out_last)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
      return (x >> n) | (x << (32 - n));
   endfunction

   function automatic logic [31:0] ssig0(input logic [31:0] x);
      return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
   endfunction

   function automatic logic [31:0] ssig1(input logic [31:0] x);
      return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
   endfunction

   // Fill exp_w from msg using the standard schedule recurrence.
   task automatic compute_model();
      for (int t = 0; t < 64; t++) begin
         if (t < 16) exp_w[t] = msg[t];
         else exp_w[t] = ssig1(exp_w[t-2]) + exp_w[t-7] + ssig0(exp_w[t-15]) + exp_w[t-16];
      end
   endtask

   function automatic logic [31:0] exp_out(input int t);
      return KADD ? (exp_w[t] + KREF[t]) : exp_w[t];
   endfunction

   task automatic set_abc();
      for (int i = 0; i < 16; i++) msg[i] = 32'h0;
      msg[0]  = 32'h61626380;
      msg[15] = 32'h00000018;
      compute_model();
   endtask

   // Drive the 16 words of msg. mode 0: back-to-back, 1: bubble every third
   // cycle, 2: random bubbles. Returns at the falling edge after the last word.
   task automatic drive_load(input int mode);
      int k;
      int cyc;
      bit gap;
      k = 0;
      cyc = 0;
      while (k < 16 && cyc < 400) begin
         @(negedge clk);
         gap = (mode == 1) ? (cyc % 3 == 2) : (mode == 2) ? ($urandom_range(0, 3) == 0) : 1'b0;
         if (gap) begin
            in_valid = 1'b0;
            in_word  = $urandom;
         end else begin
            in_valid = 1'b1;
            in_word  = msg[k];
            k++;
         end
         cyc++;
      end
      @(negedge clk);
      in_valid = 1'b0;
      in_word  = $urandom;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      #12;
      total++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_idx !== 6'd0 || out_last !== 1'b0) begin
         bad++;
         $display("[TB] FAIL reset_hold: in_ready=%b out_valid=%b out_idx=%0d out_last=%b required 1 0 0 0",
                  in_ready, out_valid, out_idx, out_last);
      end
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      total++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_idx !== 6'd0 || out_last !== 1'b0 ||
          out_word !== (KADD ? KREF[0] : 32'h0)) begin
         bad++;
         $display("[TB] FAIL reset_release: in_ready=%b out_valid=%b out_idx=%0d out_last=%b out_word=%h",
                  in_ready, out_valid, out_idx, out_last, out_word);
      end
   endtask

   task automatic test_abc();
      int t;
      set_abc();
      out_ready = 1'b1;
      drive_load(0);
      total++;
      if (out_valid !== 1'b1 || out_idx !== 6'd0) begin
         bad++;
         $display("[TB] FAIL abc_valid_rise: out_valid=%b out_idx=%0d required 1 0", out_valid, out_idx);
      end
      t = 0;
      for (int cyc = 0; cyc < 200 && t < 64; cyc++) begin
         if (out_valid) begin
            cap[t] = out_word;
            total++;
            if (out_word !== exp_out(t) || out_idx !== 6'(t) || out_last !== (t == 63)) begin
               bad++;
               $display("[TB] FAIL abc_word t=%0d: word=%h idx=%0d last=%b required %h %0d %b",
                        t, out_word, out_idx, out_last, exp_out(t), t, (t == 63));
            end
            t++;
         end
         @(negedge clk);
      end
      total++;
      if (t != 64) begin
         bad++;
         $display("[TB] FAIL abc_timeout: got %0d words required 64", t);
      end
      total++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
         bad++;
         $display("[TB] FAIL abc_return_load: in_ready=%b out_valid=%b required 1 0", in_ready, out_valid);
      end
      if (!KADD) begin
         total++;
         if (cap[0] !== 32'h61626380 || cap[15] !== 32'h00000018 ||
             cap[16] !== 32'h61626380 || cap[17] !== 32'h000F0000) begin
            bad++;
            $display("[TB] FAIL abc_known_words: W0=%h W15=%h W16=%h W17=%h required 61626380 00000018 61626380 000f0000",
                     cap[0], cap[15], cap[16], cap[17]);
         end
      end else begin
         total++;
         if (cap[0] !== 32'hA3EC9318) begin
            bad++;
            $display("[TB] FAIL kadd_first_word: got %h required a3ec9318", cap[0]);
         end
      end
   endtask

   task automatic test_backpressure();
      int t;
      logic        held;
      logic [31:0] h_word;
      logic [5:0]  h_idx;
      logic        h_last;
      set_abc();
      out_ready = 1'b0;
      drive_load(0);
      t = 0;
      held = 1'b0;
      h_word = '0;
      h_idx = '0;
      h_last = 1'b0;
      for (int cyc = 0; cyc < 400 && t < 64; cyc++) begin
         if (held) begin
            total++;
            if (out_word !== h_word || out_idx !== h_idx || out_last !== h_last) begin
               bad++;
               $display("[TB] FAIL bp_stable: word=%h idx=%0d last=%b required %h %0d %b",
                        out_word, out_idx, out_last, h_word, h_idx, h_last);
            end
         end
         out_ready = (cyc % 2 == 1);
         held = out_valid && !out_ready;
         h_word = out_word;
         h_idx = out_idx;
         h_last = out_last;
         if (out_valid && out_ready) begin
            total++;
            if (out_word !== exp_out(t) || out_idx !== 6'(t)) begin
               bad++;
               $display("[TB] FAIL bp_word t=%0d: word=%h idx=%0d required %h %0d",
                        t, out_word, out_idx, exp_out(t), t);
            end
            t++;
         end
         @(negedge clk);
      end
      out_ready = 1'b1;
      total++;
      if (t != 64 || in_ready !== 1'b1) begin
         bad++;
         $display("[TB] FAIL bp_complete: words=%0d in_ready=%b required 64 1", t, in_ready);
      end
   endtask

   task automatic test_bubbles();
      int t;
      set_abc();
      out_ready = 1'b1;
      drive_load(1);
      total++;
      if (out_valid !== 1'b1 || out_idx !== 6'd0 || out_word !== exp_out(0)) begin
         bad++;
         $display("[TB] FAIL bubble_start: valid=%b idx=%0d word=%h required 1 0 %h",
                  out_valid, out_idx, out_word, exp_out(0));
      end
      t = 0;
      for (int cyc = 0; cyc < 200 && t < 64; cyc++) begin
         if (out_valid) begin
            total++;
            if (out_word !== exp_out(t) || out_idx !== 6'(t)) begin
               bad++;
               $display("[TB] FAIL bubble_word t=%0d: word=%h idx=%0d required %h %0d",
                        t, out_word, out_idx, exp_out(t), t);
            end
            t++;
         end
         @(negedge clk);
      end
      total++;
      if (t != 64) begin
         bad++;
         $display("[TB] FAIL bubble_timeout: got %0d words required 64", t);
      end
   endtask

   task automatic test_abort();
      int t;
      bit hit;
      set_abc();
      out_ready = 1'b1;
      drive_load(0);
      hit = 1'b0;
      for (int cyc = 0; cyc < 100 && !hit; cyc++) begin
         if (out_valid && out_idx == 6'd30) begin
            clear = 1'b1;
            hit = 1'b1;
         end else begin
            @(negedge clk);
         end
      end
      @(negedge clk);
      clear = 1'b0;
      total++;
      if (!hit || out_valid !== 1'b0 || in_ready !== 1'b1) begin
         bad++;
         $display("[TB] FAIL abort_state: reached=%b out_valid=%b in_ready=%b required 1 0 1",
                  hit, out_valid, in_ready);
      end
      drive_load(0);
      total++;
      if (out_valid !== 1'b1 || out_idx !== 6'd0 || out_word !== exp_out(0)) begin
         bad++;
         $display("[TB] FAIL abort_reload: valid=%b idx=%0d word=%h required 1 0 %h",
                  out_valid, out_idx, out_word, exp_out(0));
      end
      t = 0;
      for (int cyc = 0; cyc < 200 && t < 64; cyc++) begin
         if (out_valid) begin
            total++;
            if (out_word !== exp_out(t) || out_idx !== 6'(t)) begin
               bad++;
               $display("[TB] FAIL abort_word t=%0d: word=%h idx=%0d required %h %0d",
                        t, out_word, out_idx, exp_out(t), t);
            end
            t++;
         end
         @(negedge clk);
      end
      total++;
      if (t != 64) begin
         bad++;
         $display("[TB] FAIL abort_timeout: got %0d words required 64", t);
      end
   endtask

   task automatic test_random_back_to_back();
      int t;
      for (int blk = 0; blk < 4; blk++) begin
         for (int i = 0; i < 16; i++) msg[i] = $urandom;
         compute_model();
         drive_load(blk == 0 ? 0 : 2);
         t = 0;
         for (int cyc = 0; cyc < 600 && t < 64; cyc++) begin
            out_ready = ($urandom_range(0, 2) != 0);
            if (out_valid && out_ready) begin
               total++;
               if (out_word !== exp_out(t) || out_idx !== 6'(t) || out_last !== (t == 63)) begin
                  bad++;
                  $display("[TB] FAIL rand_word blk=%0d t=%0d: word=%h idx=%0d last=%b required %h %0d %b",
                           blk, t, out_word, out_idx, out_last, exp_out(t), t, (t == 63));
               end
               t++;
            end
            @(negedge clk);
         end
         out_ready = 1'b1;
         total++;
         if (t != 64) begin
            bad++;
            $display("[TB] FAIL rand_timeout blk=%0d: got %0d words required 64", blk, t);
         end
      end
   endtask

   task automatic test_async_reset();
      set_abc();
      out_ready = 1'b1;
      drive_load(0);
      for (int i = 0; i < 10; i++) @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      total++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_idx !== 6'd0 || out_last !== 1'b0 ||
          out_word !== (KADD ? KREF[0] : 32'h0)) begin
         bad++;
         $display("[TB] FAIL async_reset: in_ready=%b out_valid=%b out_idx=%0d out_last=%b out_word=%h",
                  in_ready, out_valid, out_idx, out_last, out_word);
      end
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      total++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
         bad++;
         $display("[TB] FAIL async_reset_release: in_ready=%b out_valid=%b required 1 0", in_ready, out_valid);
      end
   endtask

   initial begin
      rst_n     = 1'b0;
      clear     = 1'b0;
      in_valid  = 1'b0;
      in_word   = 32'h0;
      out_ready = 1'b1;
      $display("[TB] starting, KADD=%0d", KADD);
      test_reset();
      test_abc();
      test_backpressure();
      test_bubbles();
      test_abort();
      test_random_back_to_back();
      test_async_reset();
      test_abc();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
